hop_seq_ctrl: RTL

Parametrised frequency-hop sequencer for the tag-chip transmitter. It runs a configurable number of hops per sequence: one local-sync preamble, then a sync gap and a scan/transmit phase for each hop. Hop codes come from a run-time-writable table, not a compile-time memory file. It drives the scan-chain hop controller reset, supplies the per-hop code and NCO phase increment to the signal generator, and supports single-shot, continuous-loop and abort operation.

---
 rtl/hop_seq_pkg.sv | 16 +
 rtl/hop_seq_ctrl_if.sv | 46 ++++
 rtl/hop_code_ram.sv | 37 +++
 rtl/hop_seq_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/hop_seq_pkg.sv
// hop_seq_pkg: shared constants for the frequency-hop sequencer.
//   STATE_W            width of the sequencer state code
//   ST_*               state encodings (also visible on the state output)
//   DEF_START_PH_INC   default NCO increment for hop 0
//   DEF_HOP_DPH_INC    default increment step between consecutive hops
package hop_seq_pkg;
  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE      = 2'b00;
  localparam logic [STATE_W-1:0] ST_LOC_SYNCH = 2'b01;
  localparam logic [STATE_W-1:0] ST_HOP_SYNCH = 2'b10;
  localparam logic [STATE_W-1:0] ST_HOP_TX    = 2'b11;

  localparam int DEF_START_PH_INC = 8192;
  localparam int DEF_HOP_DPH_INC  = 131072;
endpackage

// File: rtl/hop_seq_ctrl_if.sv
// hop_seq_ctrl_if: control, configuration, table-write and status bundle of
// the hop sequencer.
//   master: drives start/abort/cfg_*/code_wr_*/hop_done, observes status
//   slave : the sequencer itself
//   status: hop_code, hop_idx, hop_phase_inc, hop_rst, tx_trig, busy,
//           seq_done, state
interface hop_seq_ctrl_if
  import hop_seq_pkg::*;
#(
  parameter int PHASE_WIDTH   = 24,
  parameter int CODE_WIDTH    = 32,
  parameter int HOP_IDX_WIDTH = 6
);
  logic                     start;
  logic                     abort;
  logic [HOP_IDX_WIDTH:0]   cfg_num_hops;
  logic [PHASE_WIDTH-1:0]   cfg_loc_len;
  logic [PHASE_WIDTH-1:0]   cfg_sync_len;
  logic                     cfg_loop;
  logic                     code_wr_en;
  logic [HOP_IDX_WIDTH-1:0] code_wr_addr;
  logic [CODE_WIDTH-1:0]    code_wr_data;
  logic                     hop_done;
  logic [CODE_WIDTH-1:0]    hop_code;
  logic [HOP_IDX_WIDTH-1:0] hop_idx;
  logic [PHASE_WIDTH-1:0]   hop_phase_inc;
  logic                     hop_rst;
  logic                     tx_trig;
  logic                     busy;
  logic                     seq_done;
  logic [STATE_W-1:0]       state;

  modport master (
    output start, abort, cfg_num_hops, cfg_loc_len, cfg_sync_len, cfg_loop,
           code_wr_en, code_wr_addr, code_wr_data, hop_done,
    input  hop_code, hop_idx, hop_phase_inc, hop_rst, tx_trig, busy,
           seq_done, state
  );

  modport slave (
    input  start, abort, cfg_num_hops, cfg_loc_len, cfg_sync_len, cfg_loop,
           code_wr_en, code_wr_addr, code_wr_data, hop_done,
    output hop_code, hop_idx, hop_phase_inc, hop_rst, tx_trig, busy,
           seq_done, state
  );
endinterface

// File: rtl/hop_code_ram.sv
// hop_code_ram: hop-code table, one write port and one registered read port.
//   clk, reset : clock, async active-high reset (read register only)
//   wr_en/wr_addr/wr_data : table write; addresses >= DEPTH are dropped
//   rd_addr/rd_data       : rd_data <= mem[rd_addr] every cycle
// The array itself is never reset so codes survive a sequencer reset.
module hop_code_ram #(
  parameter int CODE_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [CODE_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [CODE_WIDTH-1:0] rd_data
);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  logic [CODE_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < DEPTH_L)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read-before-write: a same-address write this cycle is seen next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end
endmodule

// File: rtl/hop_seq_ctrl.sv
// hop_seq_ctrl: frequency-hop sequencer.
//   clk, reset : clock, async active-high reset
//   bus        : hop_seq_ctrl_if.slave
//     start/abort, cfg_* (latched on accepted start), code_wr_* (table write),
//     hop_done (end of hop from the scan controller);
//     hop_code/hop_idx/hop_phase_inc (current hop), hop_rst (first
//     HOP_SYNCH cycle), tx_trig (LOC/HOP_SYNCH), busy, seq_done, state.
module hop_seq_ctrl
  import hop_seq_pkg::*;
#(
  parameter int PHASE_WIDTH   = 24,
  parameter int CODE_WIDTH    = 32,
  parameter int NUM_HOPS_MAX  = 64,
  parameter int HOP_IDX_WIDTH = 6,
  parameter logic [PHASE_WIDTH-1:0] START_PH_INC = PHASE_WIDTH'(DEF_START_PH_INC),
  parameter logic [PHASE_WIDTH-1:0] HOP_DPH_INC  = PHASE_WIDTH'(DEF_HOP_DPH_INC)
) (
  input  logic           clk,
  input  logic           reset,
  hop_seq_ctrl_if.slave  bus
);
  localparam logic [HOP_IDX_WIDTH:0] MAX_HOPS = (HOP_IDX_WIDTH+1)'(NUM_HOPS_MAX);

  logic [STATE_W-1:0]       state_q, state_d;
  logic [PHASE_WIDTH-1:0]   cnt_q;
  logic [HOP_IDX_WIDTH-1:0] idx_q;
  logic [PHASE_WIDTH-1:0]   ph_q;
  logic                     hop_rst_q, seq_done_q;
  logic [PHASE_WIDTH-1:0]   loc_len_q, sync_len_q;
  logic [HOP_IDX_WIDTH-1:0] last_idx_q;
  logic                     loop_q;
  logic                     start_ok, cnt_zero, last_hop;

  // Down-counter reload value: a phase of length 0 behaves as length 1.
  function automatic logic [PHASE_WIDTH-1:0] cnt_load(input logic [PHASE_WIDTH-1:0] len);
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

  // Index of the final hop, with oversize hop counts clamped to the table depth.
  function automatic logic [HOP_IDX_WIDTH-1:0] last_idx(input logic [HOP_IDX_WIDTH:0] n);
    logic [HOP_IDX_WIDTH:0] c;
    c = (n > MAX_HOPS) ? MAX_HOPS : n;
    return HOP_IDX_WIDTH'(c - 1'b1);
  endfunction

  assign start_ok = bus.start && (bus.cfg_num_hops != '0);
  assign cnt_zero = (cnt_q == '0);
  assign last_hop = (idx_q == last_idx_q);

  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      if (start_ok) state_d = ST_LOC_SYNCH;
        ST_LOC_SYNCH: if (cnt_zero) state_d = ST_HOP_SYNCH;
        ST_HOP_SYNCH: if (cnt_zero) state_d = ST_HOP_TX;
        ST_HOP_TX: begin
          if (bus.hop_done) begin
            if (!last_hop)    state_d = ST_HOP_SYNCH;
            else if (loop_q)  state_d = ST_LOC_SYNCH;
            else              state_d = ST_IDLE;
          end
        end
        default:              state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      ph_q       <= START_PH_INC;
      hop_rst_q  <= 1'b0;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      // Registered pulses line up with the first cycle of the state they mark.
      hop_rst_q  <= (state_d == ST_HOP_SYNCH) && (state_q != ST_HOP_SYNCH);
      seq_done_q <= (state_q == ST_HOP_TX) && (state_d == ST_IDLE) && !bus.abort;

      if (bus.abort) begin
        idx_q <= '0;
        ph_q  <= START_PH_INC;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_ok) begin
              idx_q <= '0;
              ph_q  <= START_PH_INC;
              cnt_q <= cnt_load(bus.cfg_loc_len);
            end
          end
          ST_LOC_SYNCH: cnt_q <= cnt_zero ? cnt_load(sync_len_q) : cnt_q - 1'b1;
          ST_HOP_SYNCH: if (!cnt_zero) cnt_q <= cnt_q - 1'b1;
          ST_HOP_TX: begin
            if (bus.hop_done) begin
              if (!last_hop) begin
                idx_q <= idx_q + 1'b1;
                ph_q  <= ph_q + HOP_DPH_INC;
                cnt_q <= cnt_load(sync_len_q);
              end else if (loop_q) begin
                idx_q <= '0;
                ph_q  <= START_PH_INC;
                cnt_q <= cnt_load(loc_len_q);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Configuration snapshot; only read after the start that wrote it.
  always_ff @(posedge clk) begin
    if ((state_q == ST_IDLE) && start_ok && !bus.abort) begin
      loc_len_q  <= bus.cfg_loc_len;
      sync_len_q <= bus.cfg_sync_len;
      last_idx_q <= last_idx(bus.cfg_num_hops);
      loop_q     <= bus.cfg_loop;
    end
  end

  hop_code_ram #(
    .CODE_WIDTH (CODE_WIDTH),
    .DEPTH      (NUM_HOPS_MAX),
    .ADDR_WIDTH (HOP_IDX_WIDTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.code_wr_en),
    .wr_addr (bus.code_wr_addr),
    .wr_data (bus.code_wr_data),
    .rd_addr (idx_q),
    .rd_data (bus.hop_code)
  );

  assign bus.state         = state_q;
  assign bus.hop_idx       = idx_q;
  assign bus.hop_phase_inc = ph_q;
  assign bus.hop_rst       = hop_rst_q;
  assign bus.seq_done      = seq_done_q;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.tx_trig       = (state_q == ST_LOC_SYNCH) || (state_q == ST_HOP_SYNCH);
endmodule
